// File: rtl/restoring_divider.sv
// Sequential 8-bit unsigned restoring divider with integrated control FSM.
// Shares the multiplier front end: Run starts one division per press,
// ClearA_LoadB loads the dividend, Switches supplies dividend and divisor.
module restoring_divider (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] Switches,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        SHIFT = 3'd2,
        SUB   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t          state;
    logic [W:0]      a;      // partial remainder; bit W is the guard bit
    logic [W-1:0]    q;      // dividend shifting out, quotient shifting in
    logic [W-1:0]    d;      // divisor captured at LATCH
    logic [CW-1:0]   cnt;    // iteration index 0..7
    logic [W:0]      diff;

    // Trial subtraction; diff[W] set means the divisor did not fit.
    always_comb begin
        diff = a - {1'b0, d};
    end

    assign Aval = a[W-1:0];
    assign Bval = q;

    // Control FSM and datapath registers; Busy/Done are registered with the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            a       <= '0;
            q       <= '0;
            d       <= '0;
            cnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        state <= LATCH;
                        Busy  <= 1'b1;
                    end else if (ClearA_LoadB) begin
                        q       <= Switches;
                        a       <= '0;
                        DivZero <= 1'b0;
                    end
                end

                LATCH: begin
                    d       <= Switches;
                    a       <= '0;
                    cnt     <= '0;
                    DivZero <= 1'b0;
                    if (Switches == '0) begin
                        // Divide by zero: all-ones quotient, dividend left as remainder.
                        q       <= '1;
                        a       <= {1'b0, q};
                        DivZero <= 1'b1;
                        state   <= HOLD;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    {a, q} <= {a[W-1:0], q, 1'b0};
                    state  <= SUB;
                end

                SUB: begin
                    // Keep the difference only when it is non-negative; otherwise restore.
                    if (!diff[W]) begin
                        a    <= diff;
                        q[0] <= 1'b1;
                    end
                    if (cnt == CW'(W - 1)) begin
                        state <= HOLD;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        state <= SHIFT;
                    end
                end

                HOLD: begin
                    // Wait for Run release so a held button cannot retrigger.
                    if (!Run) begin
                        state <= IDLE;
                        Done  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: timing, corner operands, divide-by-zero,
// held Run, Switches noise, mid-operation reset and a sampled operand sweep.
module tb_restoring_divider;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Switches;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    int total = 0;
    int bad   = 0;

    restoring_divider dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .Switches     (Switches),
        .Aval         (Aval),
        .Bval         (Bval),
        .Busy         (Busy),
        .Done         (Done),
        .DivZero      (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_dividend(input logic [7:0] v);
        Switches     = v;
        ClearA_LoadB = 1'b1;
        tick();
        ClearA_LoadB = 1'b0;
    endtask

    // Press Run with divisor dv and wait (bounded) for Done; Run stays high.
    task automatic run_div(input logic [7:0] dv, input bit noise, input bit both,
                           output int edges, output int busy_cycles,
                           output int overlap, output bit timeout);
        edges       = 0;
        busy_cycles = 0;
        overlap     = 0;
        Switches    = dv;
        Run         = 1'b1;
        if (both) ClearA_LoadB = 1'b1;
        while (Done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
            ClearA_LoadB = 1'b0;
            if (Busy === 1'b1) busy_cycles++;
            if (Busy === 1'b1 && Done === 1'b1) overlap++;
            if (noise && edges >= 2) Switches = 8'($urandom);
        end
        timeout = (Done !== 1'b1);
    endtask

    task automatic release_run();
        Run = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; Switches = 8'h00;
        tick(); tick();
        Reset = 1'b0;
        total++; if (Aval !== 8'h00) begin bad++; $display("FAIL reset_aval got=%h want=00", Aval); end
        total++; if (Bval !== 8'h00) begin bad++; $display("FAIL reset_bval got=%h want=00", Bval); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done); end
        total++; if (DivZero !== 1'b0) begin bad++; $display("FAIL reset_divzero got=%b want=0", DivZero); end
    endtask

    task automatic test_basic();
        int e, bc, ov;
        bit to;
        load_dividend(8'hC8);
        total++; if (Bval !== 8'hC8) begin bad++; $display("FAIL basic_load got=%h want=c8", Bval); end
        run_div(8'h07, 1'b0, 1'b0, e, bc, ov, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
        total++; if (e != 18) begin bad++; $display("FAIL basic_latency got=%0d want=18", e); end
        total++; if (bc != 17) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=17", bc); end
        total++; if (ov != 0) begin bad++; $display("FAIL basic_busy_done_overlap got=%0d want=0", ov); end
        total++; if (Bval !== 8'h1C) begin bad++; $display("FAIL basic_quot got=%h want=1c", Bval); end
        total++; if (Aval !== 8'h04) begin bad++; $display("FAIL basic_rem got=%h want=04", Aval); end
        total++; if (DivZero !== 1'b0) begin bad++; $display("FAIL basic_divzero got=%b want=0", DivZero); end
        release_run();
        total++; if (Done !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL basic_release got=done%b busy%b want=done0 busy0", Done, Busy); end
    endtask

    task automatic test_edge_cases();
        logic [7:0] tn [5] = '{8'hFF, 8'h05, 8'hFF, 8'h00, 8'h80};
        logic [7:0] td [5] = '{8'h01, 8'h09, 8'hFF, 8'h07, 8'h02};
        logic [7:0] tq [5] = '{8'hFF, 8'h00, 8'h01, 8'h00, 8'h40};
        logic [7:0] tr [5] = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        int e, bc, ov;
        bit to;
        for (int i = 0; i < 5; i++) begin
            load_dividend(tn[i]);
            run_div(td[i], 1'b0, 1'b0, e, bc, ov, to);
            total++; if (to || Bval !== tq[i] || Aval !== tr[i]) begin
                bad++;
                $display("FAIL edge_case_%0d got=q%h r%h want=q%h r%h", i, Bval, Aval, tq[i], tr[i]);
            end
            release_run();
        end
    endtask

    task automatic test_priority();
        int e, bc, ov;
        bit to;
        load_dividend(8'h10);
        // Load value 0x03 would be taken if ClearA_LoadB won; Run must win.
        run_div(8'h03, 1'b0, 1'b1, e, bc, ov, to);
        total++; if (to || Bval !== 8'h05 || Aval !== 8'h01) begin
            bad++; $display("FAIL run_priority got=q%h r%h want=q05 r01", Bval, Aval);
        end
        release_run();
    endtask

    task automatic test_div_zero();
        int e, bc, ov;
        bit to;
        load_dividend(8'h2A);
        run_div(8'h00, 1'b0, 1'b0, e, bc, ov, to);
        total++; if (to || e != 2) begin bad++; $display("FAIL dz_latency got=%0d want=2", e); end
        total++; if (bc != 1) begin bad++; $display("FAIL dz_busy_cycles got=%0d want=1", bc); end
        total++; if (DivZero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", DivZero); end
        total++; if (Bval !== 8'hFF) begin bad++; $display("FAIL dz_quot got=%h want=ff", Bval); end
        total++; if (Aval !== 8'h2A) begin bad++; $display("FAIL dz_rem got=%h want=2a", Aval); end
        release_run();
        total++; if (DivZero !== 1'b1) begin bad++; $display("FAIL dz_sticky got=%b want=1", DivZero); end
        run_div(8'h05, 1'b0, 1'b0, e, bc, ov, to);
        total++; if (to || Bval !== 8'h33 || Aval !== 8'h00 || DivZero !== 1'b0) begin
            bad++; $display("FAIL dz_then_valid got=q%h r%h dz%b want=q33 r00 dz0", Bval, Aval, DivZero);
        end
        release_run();
        load_dividend(8'h09);
        run_div(8'h00, 1'b0, 1'b0, e, bc, ov, to);
        release_run();
        load_dividend(8'h11);
        total++; if (DivZero !== 1'b0 || Bval !== 8'h11) begin
            bad++; $display("FAIL dz_load_clear got=dz%b q%h want=dz0 q11", DivZero, Bval);
        end
    endtask

    task automatic test_hold_run();
        int e, bc, ov;
        bit to;
        int stable_bad;
        load_dividend(8'hC8);
        run_div(8'h07, 1'b0, 1'b0, e, bc, ov, to);
        stable_bad = 0;
        for (int i = 0; i < 40; i++) begin
            ClearA_LoadB = (i >= 10 && i < 20);
            Switches     = 8'h55;
            tick();
            if (Done !== 1'b1 || Busy !== 1'b0 || Bval !== 8'h1C || Aval !== 8'h04) stable_bad++;
        end
        ClearA_LoadB = 1'b0;
        total++; if (stable_bad != 0) begin bad++; $display("FAIL hold_stable got=%0d_bad_cycles want=0", stable_bad); end
        release_run();
        total++; if (Done !== 1'b0 || Busy !== 1'b0 || Bval !== 8'h1C) begin
            bad++; $display("FAIL hold_release got=done%b busy%b q%h want=done0 busy0 q1c", Done, Busy, Bval);
        end
        run_div(8'h03, 1'b0, 1'b0, e, bc, ov, to);
        total++; if (to || Bval !== 8'h09 || Aval !== 8'h01) begin
            bad++; $display("FAIL hold_second_div got=q%h r%h want=q09 r01", Bval, Aval);
        end
        release_run();
    endtask

    task automatic test_switch_noise();
        int e, bc, ov;
        bit to;
        load_dividend(8'hC8);
        run_div(8'h07, 1'b1, 1'b0, e, bc, ov, to);
        total++; if (to || e != 18 || Bval !== 8'h1C || Aval !== 8'h04) begin
            bad++; $display("FAIL noise_result got=q%h r%h edges%0d want=q1c r04 edges18", Bval, Aval, e);
        end
        release_run();
    endtask

    task automatic test_reset_mid();
        load_dividend(8'hC8);
        Switches = 8'h07;
        Run      = 1'b1;
        tick();
        Run = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", Busy); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        total++; if (Aval !== 8'h00 || Bval !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got=a%h q%h busy%b done%b dz%b want=all_zero", Aval, Bval, Busy, Done, DivZero);
        end
        tick();
        total++; if (Busy !== 1'b0 || Bval !== 8'h00) begin
            bad++; $display("FAIL midrst_stays_idle got=busy%b q%h want=busy0 q00", Busy, Bval);
        end
    endtask

    task automatic test_sweep();
        int e, bc, ov;
        bit to;
        int n, dv;
        logic [7:0] eq, er;
        for (int i = 0; i < 150; i++) begin
            n  = $urandom_range(0, 255);
            dv = $urandom_range(1, 255);
            eq = 8'(n / dv);
            er = 8'(n % dv);
            load_dividend(8'(n));
            run_div(8'(dv), 1'b0, 1'b0, e, bc, ov, to);
            total++; if (to || Bval !== eq || Aval !== er) begin
                bad++; $display("FAIL sweep_%0d_%0d got=q%h r%h want=q%h r%h", n, dv, Bval, Aval, eq, er);
            end
            release_run();
        end
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; Switches = 8'h00;
        test_reset();
        test_basic();
        test_edge_cases();
        test_priority();
        test_div_zero();
        test_hold_run();
        test_switch_noise();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
